spectrum_frame_loader: RTL and testbench
========================================

// Module: spectrum_frame_loader
// PURPOSE
//  Sequences transfer of one FFT result frame from the FFT result RAM into a
//  ping-pong bar-height RAM read by the HDMI spectrum renderer. Per frame: waits
//  for a complete FFT frame, reads every bin, converts it to a clipped bar height
//  and writes the back bank. Swaps banks only on vsync, so the display never tears.
// PARAMETERS
//  FFT_POINT  256  bins per frame (power of 2, 16..1024)
//  ADDR_W     10   bin address width; FFT_POINT <= 2**ADDR_W
//  BAR_W      12   bar-height width
//  V_ACT      720  active lines; bar height clipped to V_ACT-1
//  SHIFT      6    right shift applied to magnitude before clipping
// PORTS
//  pix_clk        in   1        pixel clock; only clock
//  rst            in   1        synchronous, active-high reset
//  vs_in          in   1        vsync from timing generator, active-high
//  fft_frame_rdy  in   1        level: FFT RAM holds a complete, unread frame
//  fft_frame_ack  out  1        1-cycle pulse: frame consumed
//  fft_rd_en      out  1        FFT RAM read strobe
//  fft_rd_addr    out  ADDR_W   FFT RAM read address (bin index)
//  fft_rd_data    in   32       {re[31:16], im[15:0]} signed, valid 1 cycle after rd_en
//  bar_wr_en      out  1        bar RAM write strobe
//  bar_wr_addr    out  ADDR_W+1 {bank, bin}
//  bar_wr_data    out  BAR_W    bar height
//  disp_bank      out  1        bank the renderer must read
//  busy           out  1        1 in LOAD/DRAIN
//  overrun_cnt    out  8        saturating count of vsyncs with load unfinished
// BEHAVIOUR
//  Reset: all strobes 0, addrs 0, bar_wr_data 0, disp_bank 0 (write bank = 1),
//   overrun_cnt 0, busy 0, state WAIT. Reset mid-load abandons it, no ack.
//  vs_edge = vs_in & ~vs_in_d (registered); vs_in_d resets to 0.
//  FSM WAIT -> LOAD when fft_frame_rdy=1 (checked every cycle in WAIT).
//   LOAD: fft_rd_en=1 each cycle, addr 0..FFT_POINT-1, one per cycle, no gaps;
//    after addr FFT_POINT-1 -> DRAIN.
//   DRAIN: flush 2-stage write pipe; on last write -> fft_frame_ack pulse
//    next cycle, -> DONE.
//   DONE: hold; on vs_edge -> disp_bank toggles, write bank = new ~disp_bank, -> WAIT.
//  Latency: bar write for bin k is 2 cycles after its read strobe (1 RAM + 1
//   compute register); total LOAD+DRAIN = FFT_POINT+2 cycles.
//  Arithmetic: |re|,|im| each 17 bit unsigned (-32768 -> 32768); mag = |re|+|im|
//   (18 bit); s = mag >> SHIFT; bar = (s > V_ACT-1) ? V_ACT-1 : s, width BAR_W.
//  vs_edge in WAIT/LOAD/DRAIN: no swap, overrun_cnt += 1 (saturate 255), load
//   continues; swap occurs at first vs_edge seen in DONE.
//  vs_edge in same cycle as final DRAIN write: state not yet DONE -> overrun,
//   no swap.
//  fft_frame_rdy dropping during LOAD is ignored; frame completes.
//  bar_wr_addr bank bit is always ~disp_bank; disp_bank changes only in DONE.
// STRUCTURE
//  Package spectrum_pkg: FFT_POINT, ADDR_W, BAR_W defaults; state encoding
//   (WAIT, LOAD, DRAIN, DONE); magnitude width constants.
//  Sub-module spectrum_mag_scale: abs/sum/shift/clip, 1 registered stage.
//  Top: FSM, address counter, valid shift pipe, vsync edge detect, bank reg.
// TESTING
//  1 Reset, rdy=1: rd addrs 0..255 on consecutive cycles; writes to bank 1 at
//    +2 cycles; ack pulse once; busy low after; disp_bank still 0.
//  2 After test 1, vs pulse: disp_bank 0->1 next cycle; next frame writes bank 0.
//  3 Data re=-32768,im=0 -> bar 512; re=0x7FFF,im=0x7FFF (mag 65534>>6=1023)
//    -> bar 719; re=64,im=-64 -> bar 2.
//  4 vs pulse mid-LOAD at bin 100: overrun_cnt 0->1, no swap, all 256 writes
//    complete, swap on following vs.
//  5 300 vs pulses with rdy=0: overrun_cnt saturates at 255; no rd_en, no ack.
//  6 rst asserted at bin 50: next cycle rd_en=0, state WAIT, disp_bank 0,
//    no ack; new rdy restarts load from addr 0.

Source files
------------

// File: rtl/spectrum_pkg.sv
// Shared defaults, magnitude widths and FSM encoding for the spectrum frame loader.
package spectrum_pkg;

    localparam int unsigned DEF_FFT_POINT = 256;
    localparam int unsigned DEF_ADDR_W    = 10;
    localparam int unsigned DEF_BAR_W     = 12;
    localparam int unsigned DEF_V_ACT     = 720;
    localparam int unsigned DEF_SHIFT     = 6;

    // |re|, |im| need one extra bit for -32768; their sum needs one more
    localparam int unsigned ABS_W = 17;
    localparam int unsigned MAG_W = 18;

    typedef enum logic [1:0] {
        StWait,
        StLoad,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/spectrum_mag_scale.sv
// Converts one {re, im} FFT bin into a clipped bar height, one registered stage.
module spectrum_mag_scale
    import spectrum_pkg::*;
#(
    parameter int unsigned BAR_W = DEF_BAR_W,
    parameter int unsigned V_ACT = DEF_V_ACT,
    parameter int unsigned SHIFT = DEF_SHIFT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [31:0]      i_data,
    output logic [BAR_W-1:0] o_bar
);

    logic signed [15:0] w_re;
    logic signed [15:0] w_im;
    logic [ABS_W-1:0]   w_re_abs;
    logic [ABS_W-1:0]   w_im_abs;
    logic [MAG_W-1:0]   w_mag;
    logic [MAG_W-1:0]   w_shr;
    logic [BAR_W-1:0]   w_bar;
    logic [BAR_W-1:0]   r_bar;

    assign w_re = i_data[31:16];
    assign w_im = i_data[15:0];

    assign w_re_abs = w_re[15] ? (17'd0 - {w_re[15], w_re}) : {1'b0, w_re};
    assign w_im_abs = w_im[15] ? (17'd0 - {w_im[15], w_im}) : {1'b0, w_im};

    assign w_mag = {1'b0, w_re_abs} + {1'b0, w_im_abs};
    assign w_shr = w_mag >> SHIFT;
    assign w_bar = (w_shr > MAG_W'(V_ACT - 1)) ? BAR_W'(V_ACT - 1) : w_shr[BAR_W-1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bar <= '0;
        end else if (i_en) begin
            r_bar <= w_bar;
        end
    end

    assign o_bar = r_bar;

endmodule

// File: rtl/spectrum_frame_loader.sv
// Moves one FFT frame into the back bank of a ping-pong bar RAM and swaps
// banks on vsync once the frame is complete.
module spectrum_frame_loader
    import spectrum_pkg::*;
#(
    parameter int unsigned FFT_POINT = DEF_FFT_POINT,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned BAR_W     = DEF_BAR_W,
    parameter int unsigned V_ACT     = DEF_V_ACT,
    parameter int unsigned SHIFT     = DEF_SHIFT
) (
    input  logic              i_pix_clk,
    input  logic              i_rst,
    input  logic              i_vs_in,
    input  logic              i_fft_frame_rdy,
    output logic              o_fft_frame_ack,
    output logic              o_fft_rd_en,
    output logic [ADDR_W-1:0] o_fft_rd_addr,
    input  logic [31:0]       i_fft_rd_data,
    output logic              o_bar_wr_en,
    output logic [ADDR_W:0]   o_bar_wr_addr,
    output logic [BAR_W-1:0]  o_bar_wr_data,
    output logic              o_disp_bank,
    output logic              o_busy,
    output logic [7:0]        o_overrun_cnt
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FFT_POINT - 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_addr_p1;
    logic [ADDR_W-1:0] r_addr_p2;
    logic [1:0]        r_vld;
    logic              r_vs_d;
    logic              r_disp_bank;
    logic              r_ack;
    logic [7:0]        r_overrun;
    logic              w_vs_edge;
    logic              w_last_rd;
    logic              w_last_wr;
    logic              w_rd_en;
    logic              w_busy;
    logic              w_ack_nxt;

    assign w_vs_edge = i_vs_in & ~r_vs_d;
    assign w_last_rd = (r_addr == LAST_ADDR);
    // Last write is the one with nothing left behind it in the pipe
    assign w_last_wr = r_vld[1] & ~r_vld[0];

    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            r_state <= StWait;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StWait:  if (i_fft_frame_rdy) w_state_nxt = StLoad;
            StLoad:  if (w_last_rd) w_state_nxt = StDrain;
            StDrain: if (w_last_wr) w_state_nxt = StDone;
            StDone:  if (w_vs_edge) w_state_nxt = StWait;
            default: w_state_nxt = StWait;
        endcase
    end

    always_comb begin
        w_rd_en   = 1'b0;
        w_busy    = 1'b0;
        w_ack_nxt = 1'b0;
        case (r_state)
            StLoad: begin
                w_rd_en = 1'b1;
                w_busy  = 1'b1;
            end
            StDrain: begin
                w_busy    = 1'b1;
                w_ack_nxt = w_last_wr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            r_addr      <= '0;
            r_addr_p1   <= '0;
            r_addr_p2   <= '0;
            r_vld       <= '0;
            r_vs_d      <= 1'b0;
            r_disp_bank <= 1'b0;
            r_ack       <= 1'b0;
            r_overrun   <= '0;
        end else begin
            if (r_state == StLoad) begin
                r_addr <= w_last_rd ? '0 : r_addr + 1'b1;
            end
            r_addr_p1 <= r_addr;
            r_addr_p2 <= r_addr_p1;
            r_vld     <= {r_vld[0], w_rd_en};
            r_vs_d    <= i_vs_in;
            r_ack     <= w_ack_nxt;
            if (w_vs_edge) begin
                if (r_state == StDone) begin
                    r_disp_bank <= ~r_disp_bank;
                end else if (r_overrun != 8'hFF) begin
                    r_overrun <= r_overrun + 8'd1;
                end
            end
        end
    end

    spectrum_mag_scale #(
        .BAR_W (BAR_W),
        .V_ACT (V_ACT),
        .SHIFT (SHIFT)
    ) u_mag_scale (
        .i_clk  (i_pix_clk),
        .i_rst  (i_rst),
        .i_en   (r_vld[0]),
        .i_data (i_fft_rd_data),
        .o_bar  (o_bar_wr_data)
    );

    assign o_fft_rd_en     = w_rd_en;
    assign o_fft_rd_addr   = r_addr;
    assign o_busy          = w_busy;
    assign o_fft_frame_ack = r_ack;
    assign o_bar_wr_en     = r_vld[1];
    assign o_bar_wr_addr   = {~r_disp_bank, r_addr_p2};
    assign o_disp_bank     = r_disp_bank;
    assign o_overrun_cnt   = r_overrun;

endmodule

// File: tb/tb_spectrum_frame_loader.sv
// Directed-sequence bench with random bin data, checked against a plain-arithmetic bar model.
module tb_spectrum_frame_loader;

    localparam int N      = 256;
    localparam int ADDR_W = 10;
    localparam int BAR_W  = 12;
    localparam int V_ACT  = 720;
    localparam int SHIFT  = 6;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } ev_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              vs;
    logic              rdy;
    logic              ack;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data = '0;
    logic              wr_en;
    logic [ADDR_W:0]   wr_addr;
    logic [BAR_W-1:0]  wr_data;
    logic              disp_bank;
    logic              busy;
    logic [7:0]        overrun;

    logic [31:0] ram [N];
    ev_t         rd_q[$];
    ev_t         wr_q[$];
    int          ack_q[$];
    int          cyc = 0;
    int          rst_cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    spectrum_frame_loader #(
        .FFT_POINT (N),
        .ADDR_W    (ADDR_W),
        .BAR_W     (BAR_W),
        .V_ACT     (V_ACT),
        .SHIFT     (SHIFT)
    ) dut (
        .i_pix_clk       (clk),
        .i_rst           (rst),
        .i_vs_in         (vs),
        .i_fft_frame_rdy (rdy),
        .o_fft_frame_ack (ack),
        .o_fft_rd_en     (rd_en),
        .o_fft_rd_addr   (rd_addr),
        .i_fft_rd_data   (rd_data),
        .o_bar_wr_en     (wr_en),
        .o_bar_wr_addr   (wr_addr),
        .o_bar_wr_data   (wr_data),
        .o_disp_bank     (disp_bank),
        .o_busy          (busy),
        .o_overrun_cnt   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // FFT result RAM: one cycle read latency
    always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr[7:0]];

    always @(negedge clk) begin
        if (rd_en) rd_q.push_back('{addr: int'(rd_addr), data: 0, cyc: cyc});
        if (wr_en) wr_q.push_back('{addr: int'(wr_addr), data: int'(wr_data), cyc: cyc});
        if (ack) ack_q.push_back(cyc);
    end

    function automatic int bar_of(input logic [31:0] d);
        int re, im, mag, s;
        re  = int'($signed(d[31:16]));
        im  = int'($signed(d[15:0]));
        mag = (re < 0 ? -re : re) + (im < 0 ? -im : im);
        s   = mag / (1 << SHIFT);
        return (s > V_ACT - 1) ? V_ACT - 1 : s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill_ram();
        for (int i = 0; i < N; i++) begin
            ram[i] = (i % 16 == 5) ? 32'h8000_8000 : $urandom();
        end
    endtask

    task automatic pulse_vs();
        @(negedge clk);
        vs = 1'b1;
        @(negedge clk);
        vs = 1'b0;
    endtask

    task automatic run_frame(input int vs_bin, input int rst_bin);
        bit done;
        done = 1'b0;
        @(posedge clk);
        rd_q.delete();
        wr_q.delete();
        ack_q.delete();
        @(negedge clk);
        rdy = 1'b1;
        for (int k = 0; k < 1000 && !done; k++) begin
            @(negedge clk);
            vs = 1'b0;
            if (rd_en) rdy = 1'b0;
            if (rd_en && int'(rd_addr) == vs_bin) vs = 1'b1;
            if (rd_en && int'(rd_addr) == rst_bin) begin
                rst     = 1'b1;
                rst_cyc = cyc;
                done    = 1'b1;
            end
            if (ack) done = 1'b1;
        end
        vs  = 1'b0;
        rdy = 1'b0;
        if (rst_bin < 0) begin
            check("frame_ack_seen", done, 1);
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic check_frame(input int bank);
        check("rd_count", rd_q.size(), N);
        for (int i = 0; i < rd_q.size() && i < N; i++) begin
            check($sformatf("rd_addr[%0d]", i), rd_q[i].addr, i);
            if (i > 0) check($sformatf("rd_gap[%0d]", i), rd_q[i].cyc - rd_q[i-1].cyc, 1);
        end
        check("wr_count", wr_q.size(), N);
        for (int i = 0; i < wr_q.size() && i < N; i++) begin
            check($sformatf("wr_addr[%0d]", i), wr_q[i].addr, (bank << ADDR_W) + i);
            check($sformatf("wr_data[%0d]", i), wr_q[i].data, bar_of(ram[i]));
            if (i < rd_q.size()) begin
                check($sformatf("wr_latency[%0d]", i), wr_q[i].cyc - rd_q[i].cyc, 2);
            end
        end
        check("ack_count", ack_q.size(), 1);
        if (ack_q.size() > 0 && wr_q.size() > 0) begin
            check("ack_after_last_wr", ack_q[0] - wr_q[wr_q.size()-1].cyc, 1);
        end
        check("busy_after_frame", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int late;
        rst = 1'b1;
        vs  = 1'b0;
        rdy = 1'b0;
        fill_ram();
        repeat (3) @(negedge clk);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_bin", wr_addr[ADDR_W-1:0], 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_ack", ack, 0);
        check("rst_disp_bank", disp_bank, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Test 1: full frame into bank 1, no swap without vsync
        fill_ram();
        run_frame(-1, -1);
        check_frame(1);
        check("t1_disp_bank", disp_bank, 0);

        // Test 2: vsync in DONE swaps banks on the next cycle
        pulse_vs();
        check("t2_disp_bank", disp_bank, 1);
        check("t2_overrun", overrun, 0);

        // Test 3: boundary magnitudes, next frame lands in bank 0
        fill_ram();
        ram[0] = {16'h8000, 16'h0000};
        ram[1] = {16'h7FFF, 16'h7FFF};
        ram[2] = {16'h0040, 16'hFFC0};
        run_frame(-1, -1);
        check_frame(0);
        if (wr_q.size() >= 3) begin
            check("t3_bar_neg_full", wr_q[0].data, 512);
            check("t3_bar_clip", wr_q[1].data, 719);
            check("t3_bar_small", wr_q[2].data, 2);
        end
        pulse_vs();
        check("t3_disp_bank", disp_bank, 0);

        // Test 4: vsync mid-load counts an overrun and does not swap
        fill_ram();
        run_frame(100, -1);
        check_frame(1);
        check("t4_overrun", overrun, 1);
        check("t4_disp_bank", disp_bank, 0);
        pulse_vs();
        check("t4_disp_bank_swap", disp_bank, 1);
        check("t4_overrun_hold", overrun, 1);

        // Test 5: overrun counter saturates with no frame available
        @(posedge clk);
        rd_q.delete();
        wr_q.delete();
        ack_q.delete();
        for (int p = 1; p <= 300; p++) begin
            pulse_vs();
            if (p == 10) check("t5_overrun_10", overrun, 11);
            if (p == 253) check("t5_overrun_253", overrun, 254);
            if (p == 254) check("t5_overrun_254", overrun, 255);
        end
        check("t5_overrun_sat", overrun, 255);
        check("t5_no_rd", rd_q.size(), 0);
        check("t5_no_ack", ack_q.size(), 0);
        check("t5_disp_bank", disp_bank, 1);

        // Test 6: reset mid-load abandons the frame
        fill_ram();
        run_frame(-1, 50);
        @(negedge clk);
        check("t6_rd_en", rd_en, 0);
        check("t6_busy", busy, 0);
        check("t6_disp_bank", disp_bank, 0);
        check("t6_overrun", overrun, 0);
        check("t6_ack", ack, 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("t6_reads_before_rst", rd_q.size(), 51);
        check("t6_no_ack", ack_q.size(), 0);
        late = 0;
        foreach (wr_q[i]) if (wr_q[i].cyc > rst_cyc) late++;
        check("t6_no_late_writes", late, 0);
        check("t6_idle_busy", busy, 0);
        fill_ram();
        run_frame(-1, -1);
        check_frame(1);
        check("t6_disp_bank_after", disp_bank, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
